data_sync_pulse: RTL
====================

Name: data_sync_pulse

Overview:
- Parametrised successor to the single-flop enable-muxed bus register.
- Moves a multi-bit bus into the CLK domain using a multi-flop synchronised enable and a rising-edge pulse generator.
- Captures the bus exactly once per enable assertion and emits a one-cycle enable_pulse qualifying the new data.
- Sits at every CDC point in the UART/register-file datapath where a quasi-static bus is qualified by a level enable.

Parameters:
BUS_WIDTH, 8, width of unsync_bus and sync_bus.
NUM_STAGES, 2, flops in the enable synchroniser chain; values below 2 are clamped to 2.
CNT_WIDTH, 8, width of capture_cnt (used only when the optional feature is compiled in).

Ports:
CLK  input  1  destination-domain clock, rising edge.
RST  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
unsync_bus  input  BUS_WIDTH  source-domain data; must be stable from bus_enable rise until enable_pulse.
bus_enable  input  1  source-domain level enable (asynchronous to CLK).
sync_bus  output  BUS_WIDTH  registered, captured data.
enable_pulse  output  1  registered, one-CLK-cycle strobe; sync_bus is new in that cycle.
capture_cnt  output  CNT_WIDTH  present only with DATA_SYNC_PULSE_CNT_EN.

Behaviour:
- One clock; reset is synchronous and active-low (RST low at a CLK edge).
- Reset values: sync chain 0, pulse_ff 0, sync_bus 0, enable_pulse 0, capture_cnt 0.
- Sync chain:
  - sync_ff[0] <= bus_enable; sync_ff[i] <= sync_ff[i-1].
  - sync_en = sync_ff[NUM_STAGES-1].
- Pulse generator:
  - pulse_ff <= sync_en each edge.
  - pulse_gen = sync_en & ~pulse_ff (combinational).
- Capture:
  - When pulse_gen = 1 at an edge: sync_bus <= unsync_bus.
  - Otherwise sync_bus holds its value; there is no other write path.
- enable_pulse <= pulse_gen every edge. It is high for exactly 1 cycle, aligned with the first cycle sync_bus shows the new value.
- Latency: bus_enable rises before edge E0 (first sampling edge). sync_en rises after edge E0+NUM_STAGES-1. sync_bus and enable_pulse update at edge E0+NUM_STAGES, visible for the cycle following it.
  - Example: NUM_STAGES=2 gives data/pulse after the 3rd edge counting E0 as 1st.
- Held enable: bus_enable held high indefinitely produces one pulse only. A further pulse requires bus_enable low for at least NUM_STAGES+1 CLK cycles, then high again.
- Source rule: bus_enable high and low phases are each at least NUM_STAGES+1 CLK cycles. Shorter phases may be lost; loss is permitted, and at most one capture is produced per observed rise.
- Reset mid-operation:
  - All state clears, any in-flight pulse is discarded, and sync_bus returns to 0.
  - If bus_enable is still high when RST releases, a fresh pulse fires NUM_STAGES+1 edges after release, because pulse_ff restarts at 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DATA_SYNC_PULSE_CNT_EN.
- Defined:
  - capture_cnt port exists.
  - capture_cnt increments by 1 at every edge where pulse_gen = 1.
  - Wraps from 2^CNT_WIDTH-1 to 0; cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: RST=0 for 3 edges with bus_enable=1, unsync_bus=8'hA5 -> sync_bus=0, enable_pulse=0 throughout reset.
- Basic capture: NUM_STAGES=2, unsync_bus=8'h3C, bus_enable rises before edge 1 -> enable_pulse high only after edge 3, sync_bus=8'h3C from edge 3 onward.
- Held enable: bus_enable high 20 cycles, unsync_bus changed to 8'h55 at cycle 10 -> exactly one pulse, sync_bus stays 8'h3C.
- Re-arm: bus_enable low 4 cycles then high with unsync_bus=8'h81 -> second single pulse, sync_bus=8'h81.
- Depth: NUM_STAGES=4, bus_enable rises before edge 1 -> pulse after edge 5. Reset asserted at edge 3 and released -> pulse only NUM_STAGES+1 edges after release.
- Counter (macro on, CNT_WIDTH=2): 5 legal enable assertions -> capture_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/data_sync_pulse.sv
// data_sync_pulse
// Brings a quasi-static multi-bit bus into the CLK domain. The level
// bus_enable passes through a NUM_STAGES-deep synchroniser. A rising-edge
// detector on the synchronised enable captures the bus once and emits a
// one-cycle enable_pulse that qualifies the new sync_bus value.
// Optional feature: define DATA_SYNC_PULSE_CNT_EN to add the wrapping
// capture_cnt output, which counts captures.
module data_sync_pulse #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse
`ifdef DATA_SYNC_PULSE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] capture_cnt
`endif
);

    // Chain depths below 2 give no metastability protection, so they are raised to 2.
    localparam int STAGES = (NUM_STAGES < 2) ? 2 : NUM_STAGES;

    logic [STAGES-1:0]    sync_q;
    logic [STAGES-1:0]    sync_d;
    logic                 pulse_q;
    logic                 pulse_d;
    logic [BUS_WIDTH-1:0] bus_q;
    logic [BUS_WIDTH-1:0] bus_d;
    logic                 en_pulse_q;
    logic                 en_pulse_d;
    logic                 sync_en_s;
    logic                 pulse_gen_s;

    // Tap the synchronised enable and detect its rising edge.
    always_comb begin
        sync_en_s   = sync_q[STAGES-1];
        pulse_gen_s = sync_en_s & ~pulse_q;
    end

    // Compute next state. The bus register changes only on a detected rise.
    always_comb begin
        sync_d     = {sync_q[STAGES-2:0], bus_enable};
        pulse_d    = sync_en_s;
        en_pulse_d = pulse_gen_s;
        if (pulse_gen_s) begin
            bus_d = unsync_bus;
        end else begin
            bus_d = bus_q;
        end
    end

    // Synchronous active-low reset clears the chain, the edge detector and the outputs.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync_q     <= '0;
            pulse_q    <= 1'b0;
            bus_q      <= '0;
            en_pulse_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            pulse_q    <= pulse_d;
            bus_q      <= bus_d;
            en_pulse_q <= en_pulse_d;
        end
    end

    assign sync_bus     = bus_q;
    assign enable_pulse = en_pulse_q;

`ifdef DATA_SYNC_PULSE_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Advance the capture count on each detected rise; it wraps naturally at full scale.
    always_comb begin
        if (pulse_gen_s) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Capture counter register, cleared by reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign capture_cnt = cnt_q;
`endif

endmodule
